// File: rtl/jesd204_lane_align_buffer.sv
// JESD204 RX multi-lane elastic buffer: per-lane write from each lane's own
// start marker, then a lockstep read of all enabled lanes from a common pointer.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   lane_mask      : enabled lanes (static while out of reset)
//   in_data        : lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid       : per-lane write strobe
//   lane_start     : first aligned word of each lane
//   release_delay  : extra cycles held after the last lane starts
//   out_data       : aligned words, masked lanes driven 0
//   out_valid      : out_data holds a fresh aligned row
//   skew           : cycles between first and last lane start
//   state          : 0 IDLE, 1 WAIT, 2 DELAY, 3 RUN
//   overflow       : sticky per-lane write-while-full
//   underflow      : sticky per-lane read-while-empty
module jesd204_lane_align_buffer #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_LANES-1:0]            lane_mask,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_LANES-1:0]            in_valid,
    input  logic [NUM_LANES-1:0]            lane_start,
    input  logic [AW-1:0]                   release_delay,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic                            out_valid,
    output logic [AW:0]                     skew,
    output logic [1:0]                      state,
    output logic [NUM_LANES-1:0]            overflow,
    output logic [NUM_LANES-1:0]            underflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DELAY = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [NUM_LANES][DEPTH];

    logic [AW:0]          wr_ptr [NUM_LANES];
    logic [AW:0]          occ    [NUM_LANES];
    logic [AW-1:0]        wr_addr[NUM_LANES];
    logic [AW:0]          rd_ptr;
    logic [AW-1:0]        dly_cnt;
    logic [NUM_LANES-1:0] lane_started;
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] empty;
    logic [NUM_LANES-1:0] wr_en;
    logic [NUM_LANES-1:0] ovf_hit;
    logic [NUM_LANES-1:0] active;
    logic                 all_started;
    logic                 any_started;
    logic                 rd_ok;
    logic [1:0]           rel_state;

    // Occupancy uses start-of-cycle pointers, so a full lane drops its
    // write even when the same cycle also reads from it.
    always_comb begin
        full    = '0;
        empty   = '0;
        wr_en   = '0;
        ovf_hit = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            occ[i]     = wr_ptr[i] - rd_ptr;
            full[i]    = occ[i] == DEPTH_W;
            empty[i]   = lane_mask[i] && (occ[i] == '0);
            wr_en[i]   = lane_mask[i] && in_valid[i] &&
                         (lane_started[i] ? !full[i] : lane_start[i]);
            ovf_hit[i] = lane_mask[i] && lane_started[i] &&
                         in_valid[i] && full[i];
            wr_addr[i] = lane_started[i] ? wr_ptr[i][AW-1:0] : '0;
        end
    end

    assign active      = lane_started & lane_mask;
    assign any_started = |active;
    assign all_started = (|lane_mask) && (active == lane_mask);
    assign rd_ok       = ~|empty;
    assign rel_state   = (release_delay == '0) ? RUN : DELAY;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_en[i]) begin
                mem[i][wr_addr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr[i] <= '0;
            end
            lane_started <= '0;
            rd_ptr       <= '0;
            dly_cnt      <= '0;
            state        <= IDLE;
            skew         <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            overflow     <= '0;
            underflow    <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_en[i]) begin
                    wr_ptr[i]       <= lane_started[i] ? wr_ptr[i] + 1'b1
                                                       : (AW+1)'(1);
                    lane_started[i] <= 1'b1;
                end
                if (ovf_hit[i]) begin
                    overflow[i] <= 1'b1;
                end
            end

            // The FSM reacts to registered start flags, one cycle after
            // the start word lands; skew counts from that same reference.
            case (state)
                IDLE: begin
                    if (all_started) begin
                        state   <= rel_state;
                        dly_cnt <= release_delay;
                    end else if (any_started) begin
                        state <= WAIT;
                        skew  <= (AW+1)'(1);
                    end
                end
                WAIT: begin
                    if (all_started) begin
                        state   <= rel_state;
                        dly_cnt <= release_delay;
                    end else if (skew != DEPTH_W) begin
                        skew <= skew + 1'b1;
                    end
                end
                DELAY: begin
                    if (dly_cnt <= AW'(1)) begin
                        state <= RUN;
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (rd_ok) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            out_data[i*DATA_WIDTH +: DATA_WIDTH] <=
                                lane_mask[i] ? mem[i][rd_ptr[AW-1:0]] : '0;
                        end
                        out_valid <= 1'b1;
                        rd_ptr    <= rd_ptr + 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                        underflow <= underflow | empty;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jesd204_lane_align_buffer.sv
// Bench for jesd204_lane_align_buffer: random lane data and valids checked
// each cycle against a queue-based model of the alignment behaviour.
module tb_jesd204_lane_align_buffer;

    localparam int NL    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef logic [NL*DW-1:0] w_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NL-1:0] lane_mask = '0;
    w_t            in_data = '0;
    logic [NL-1:0] in_valid = '0;
    logic [NL-1:0] lane_start = '0;
    logic [AW-1:0] release_delay = '0;
    w_t            out_data;
    logic          out_valid;
    logic [AW:0]   skew;
    logic [1:0]    state;
    logic [NL-1:0] overflow;
    logic [NL-1:0] underflow;

    always #5 clk = ~clk;

    jesd204_lane_align_buffer #(
        .NUM_LANES (NL),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lane_mask    (lane_mask),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .lane_start   (lane_start),
        .release_delay(release_delay),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .skew         (skew),
        .state        (state),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    int tests = 0;
    int fails = 0;

    // Model: per-lane FIFO of accepted words, plus the release time
    // derived from the last start edge and the release delay.
    logic [DW-1:0] q [NL][$];
    bit            started [NL];
    bit            all_st;
    int            first_edge;
    int            last_edge;
    int            run_edge;
    int            e = 0;
    w_t            exp_data;
    logic          exp_valid;
    logic [NL-1:0] exp_ovf;
    logic [NL-1:0] exp_unf;

    task automatic check(input string tag, input w_t obs, input w_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) begin
            q[i].delete();
            started[i] = 0;
        end
        all_st     = 0;
        first_edge = -1;
        last_edge  = -1;
        run_edge   = 0;
        exp_data   = '0;
        exp_valid  = 0;
        exp_ovf    = '0;
        exp_unf    = '0;
    endtask

    task automatic model_edge();
        int sz [NL];
        bit ok;
        bit a;
        e++;
        if (reset) begin
            model_clear();
            return;
        end
        for (int i = 0; i < NL; i++) sz[i] = q[i].size();
        if (all_st && e > run_edge) begin
            ok = 1;
            for (int i = 0; i < NL; i++)
                if (lane_mask[i] && sz[i] == 0) ok = 0;
            if (ok) begin
                exp_valid = 1;
                for (int i = 0; i < NL; i++) begin
                    if (lane_mask[i]) exp_data[i*DW +: DW] = q[i].pop_front();
                    else exp_data[i*DW +: DW] = '0;
                end
            end else begin
                exp_valid = 0;
                for (int i = 0; i < NL; i++)
                    if (lane_mask[i] && sz[i] == 0) exp_unf[i] = 1;
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (lane_mask[i] && in_valid[i]) begin
                if (started[i]) begin
                    if (sz[i] == DEPTH) exp_ovf[i] = 1;
                    else q[i].push_back(in_data[i*DW +: DW]);
                end else if (lane_start[i]) begin
                    started[i] = 1;
                    q[i].push_back(in_data[i*DW +: DW]);
                    if (first_edge < 0) first_edge = e;
                end
            end
        end
        if (!all_st && lane_mask != '0) begin
            a = 1;
            for (int i = 0; i < NL; i++)
                if (lane_mask[i] && !started[i]) a = 0;
            if (a) begin
                all_st    = 1;
                last_edge = e;
                run_edge  = e + 1 + int'(release_delay);
            end
        end
    endtask

    task automatic tick();
        int sk;
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", w_t'(out_valid), w_t'(exp_valid));
        check("out_data", out_data, exp_data);
        check("overflow", w_t'(overflow), w_t'(exp_ovf));
        check("underflow", w_t'(underflow), w_t'(exp_unf));
        check("in_run", w_t'(state == 2'd3),
              w_t'(all_st && e >= run_edge));
        if (first_edge < 0) check("idle", w_t'(state), w_t'(0));
        if (all_st && e > last_edge) begin
            sk = last_edge - first_edge;
            if (sk > DEPTH) sk = DEPTH;
            check("skew", w_t'(skew), w_t'(sk));
        end
    endtask

    task automatic do_reset(input logic [NL-1:0] mask);
        reset      = 1;
        lane_mask  = mask;
        in_valid   = '0;
        lane_start = '0;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic run_seq(input int st0, input int st1, input int st2,
                           input int st3, input int d, input int n,
                           input int gl, input int gf, input int gn,
                           input int prob);
        int st [NL];
        st = '{st0, st1, st2, st3};
        release_delay = AW'(d);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NL; i++) begin
                lane_start[i] = (c == st[i]);
                in_valid[i]   = (c == st[i]) ||
                                (int'($urandom_range(99)) < prob);
                if (i == gl && c >= gf && c < gf + gn) in_valid[i] = 0;
                in_data[i*DW +: DW] = $urandom;
            end
            tick();
        end
        in_valid   = '0;
        lane_start = '0;
    endtask

    initial begin
        model_clear();

        // staggered starts, D=3
        do_reset(4'hF);
        run_seq(10, 12, 13, 15, 3, 60, -1, 0, 0, 100);
        check("skew_stagger", w_t'(skew), w_t'(5));
        check("run_stagger", w_t'(state), w_t'(3));

        // simultaneous start, D=0, lane 2 gap
        do_reset(4'hF);
        run_seq(5, 5, 5, 5, 0, 30, 2, 12, 3, 100);
        check("skew_same", w_t'(skew), w_t'(0));
        check("unf_gap", w_t'(underflow), w_t'(4'b0100));

        // random starts, delays and gaps
        for (int k = 0; k < 3; k++) begin
            do_reset(4'hF);
            run_seq(int'($urandom_range(20)), int'($urandom_range(20)),
                    int'($urandom_range(20)), int'($urandom_range(20)),
                    int'($urandom_range(7)), 120, -1, 0, 0, 70);
        end

        // lane 1 never starts: lane 0 fills and overflows
        do_reset(4'b0011);
        run_seq(2, -1, -1, -1, 0, 80, -1, 0, 0, 100);
        check("ovf_fill", w_t'(overflow), w_t'(4'b0001));
        check("wait_stuck", w_t'(state), w_t'(1));
        check("skew_sat", w_t'(skew), w_t'(DEPTH));

        // lane 2 masked while it toggles its inputs
        do_reset(4'b1011);
        run_seq(3, 7, 4, 6, 2, 40, -1, 0, 0, 90);
        check("mask_lane2", w_t'(out_data[2*DW +: DW]), w_t'(0));
        check("mask_flags", w_t'(overflow[2] | underflow[2]), w_t'(0));
        check("mask_run", w_t'(state), w_t'(3));

        // one-cycle reset while running, then realign
        reset = 1;
        tick();
        reset = 0;
        check("rst_state", w_t'(state), w_t'(0));
        check("rst_valid", w_t'(out_valid), w_t'(0));
        check("rst_flags", w_t'({overflow, underflow}), w_t'(0));
        do_reset(4'hF);
        run_seq(1, 4, 2, 3, 1, 40, -1, 0, 0, 100);
        check("skew_realign", w_t'(skew), w_t'(3));
        check("valid_realign", w_t'(out_valid), w_t'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
